// File: rtl/dl_arb_pkg.sv
// dl_arb_pkg: shared types and helpers for the design_lib arbiters.
// Field widths are sized for the largest supported requester count, and
// arbiters slice them down to their own index width.
package dl_arb_pkg;

  localparam int unsigned MAX_REQS  = 32;
  localparam int unsigned MAX_IDX_W = 5;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  typedef struct packed {
    logic                 locked;
    logic [MAX_IDX_W-1:0] lock_idx;
  } lock_st_t;

  // Scan-based round-robin pick: first set bit of val at or after ptr, modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQS-1:0]  val,
                                       input logic [MAX_IDX_W-1:0] ptr,
                                       input int unsigned          n);
    rr_pick_t    res;
    int unsigned pos;
    res = '0;
    if (n != 0) begin
      for (int unsigned k = 0; k < MAX_REQS; k++) begin
        pos = (32'(ptr) + k) % n;
        if ((k < n) && !res.found && val[pos[MAX_IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = pos[MAX_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dl_rr_arb_pick.sv
// dl_rr_arb_pick: combinational round-robin pick.
// Rotates val so that ptr lands on bit 0, takes the lowest set bit, then
// rotates the offset back into an absolute index.
module dl_rr_arb_pick
  import dl_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQS = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] val,
  input  logic [IDX_W-1:0]    ptr,
  output logic [IDX_W-1:0]    idx,
  output logic [NUM_REQS-1:0] oh,
  output logic                found
);

  localparam logic [IDX_W:0] N_EXT = NUM_REQS[IDX_W:0];

  logic [NUM_REQS-1:0] rot;
  logic [IDX_W-1:0]    ofs;
  logic [IDX_W:0]      sum;

  // Rotate, priority-encode from bit 0, unrotate with a single modulo step.
  always_comb begin
    rot   = NUM_REQS'({val, val} >> ptr);
    found = 1'b0;
    ofs   = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        ofs   = IDX_W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, ofs};
    if (sum >= N_EXT) sum = sum - N_EXT;
    idx = found ? sum[IDX_W-1:0] : '0;
    oh  = found ? (NUM_REQS'(1) << idx) : '0;
  end

endmodule

// File: rtl/dl_rr_arb.sv
// dl_rr_arb: round-robin arbiter sharing one valid/ready channel among
// NUM_REQS requesters.
// Build option: define DL_RR_ARB_OUTREG_EN to put a one-entry register on the
// output channel (1-cycle latency, full throughput). Default is combinational.
//
// lock state | meaning
// -----------+------------------------------------------------------------
// unlocked   | grant follows the round-robin pick from prio_ptr
// locked     | downstream stalled; grant held on lock_idx until handshake
module dl_rr_arb
  import dl_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQS = 4,   // >= 2
  parameter  int unsigned NUM_BITS = 32,
  localparam int unsigned IDX_W    = $clog2(NUM_REQS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQS-1:0] req_val,
  input  logic [NUM_BITS-1:0] req_data [NUM_REQS],
  output logic [NUM_REQS-1:0] req_rdy,
  output logic                out_val,
  output logic [NUM_BITS-1:0] out_data,
  input  logic                out_rdy,
  output logic [IDX_W-1:0]    grant_idx,
  output logic [NUM_REQS-1:0] grant_oh
);

  logic [IDX_W-1:0]    prio_ptr;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_REQS-1:0] pick_oh;
  logic                pick_found;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NUM_REQS - 1)) ? '0 : g + 1'b1;
  endfunction

  dl_rr_arb_pick #(
    .NUM_REQS (NUM_REQS)
  ) u_pick (
    .val   (req_val),
    .ptr   (prio_ptr),
    .idx   (pick_idx),
    .oh    (pick_oh),
    .found (pick_found)
  );

`ifdef DL_RR_ARB_OUTREG_EN

  logic accept;

  // Register takes a new beat when it is empty or draining this cycle.
  always_comb begin
    accept   = !out_val || out_rdy;
    req_rdy  = accept ? pick_oh : '0;
    grant_oh = '0;
    for (int i = 0; i < NUM_REQS; i++)
      grant_oh[i] = out_val && (grant_idx == IDX_W'(i));
  end

  // Output register; the held beat itself is the stall lock in this build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_ptr  <= '0;
      out_val   <= 1'b0;
      out_data  <= '0;
      grant_idx <= '0;
    end else if (accept) begin
      out_val <= pick_found;
      if (pick_found) begin
        out_data  <= req_data[pick_idx];
        grant_idx <= pick_idx;
        prio_ptr  <= ptr_after(pick_idx);
      end
    end
  end

`else

  lock_st_t             lock_q;
  logic [MAX_IDX_W-1:0] grant_w;

  // Grant source: held index while locked, fresh pick otherwise.
  always_comb begin
    grant_w   = lock_q.locked ? lock_q.lock_idx : MAX_IDX_W'(pick_idx);
    grant_idx = grant_w[IDX_W-1:0];
    out_data  = req_data[grant_idx];
    out_val   = lock_q.locked ? req_val[grant_idx] : pick_found;
    grant_oh  = pick_oh;
    if (lock_q.locked) begin
      grant_oh = '0;
      for (int i = 0; i < NUM_REQS; i++)
        grant_oh[i] = out_val && (grant_w == MAX_IDX_W'(i));
    end
    req_rdy = out_rdy ? grant_oh : '0;
  end

  // Lock on a stall, release and advance the pointer on a handshake.
  // A locked requester that withdraws (illegal upstream) frees the grant
  // rather than wedging the channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_ptr <= '0;
      lock_q   <= '0;
    end else if (out_val) begin
      if (out_rdy) begin
        lock_q.locked <= 1'b0;
        prio_ptr      <= ptr_after(grant_idx);
      end else begin
        lock_q.locked   <= 1'b1;
        lock_q.lock_idx <= grant_w;
      end
    end else begin
      lock_q.locked <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_dl_rr_arb.sv
// tb_dl_rr_arb: directed stimulus with a scoreboard of expected handshakes.
module tb_dl_rr_arb;

  localparam int NR = 4;
  localparam int NB = 32;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req_val;
  logic [NB-1:0] req_data [NR];
  logic [NR-1:0] req_rdy;
  logic          out_val;
  logic [NB-1:0] out_data;
  logic          out_rdy;
  logic [1:0]    grant_idx;
  logic [NR-1:0] grant_oh;

  typedef struct {
    logic [1:0]    idx;
    logic [NB-1:0] data;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  logic [NR-1:0] pend;
  logic [NB-1:0] pend_data [NR];

  dl_rr_arb #(
    .NUM_REQS (NR),
    .NUM_BITS (NB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_val   (req_val),
    .req_data  (req_data),
    .req_rdy   (req_rdy),
    .out_val   (out_val),
    .out_data  (out_data),
    .out_rdy   (out_rdy),
    .grant_idx (grant_idx),
    .grant_oh  (grant_oh)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i);
    exp_t e;
    e.idx  = 2'(i);
    e.data = req_data[i];
    sb.push_back(e);
  endtask

  // One cycle with out_rdy high, expecting a handshake from requester g.
  task automatic beat(input logic [NR-1:0] v, input int g);
    push(g);
    req_val = v;
    out_rdy = 1'b1;
    cyc();
  endtask

  // Monitor: every handshake must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && out_val && out_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL hs_unexpected: got grant %0d expected no handshake", grant_idx);
      end else begin
        mon_e = sb.pop_front();
        chk("hs_idx", 32'(grant_idx), 32'(mon_e.idx));
        chk("hs_data", out_data, mon_e.data);
        chk("hs_req_rdy", 32'(req_rdy), 32'(1) << mon_e.idx);
        chk("hs_grant_oh", 32'(grant_oh), 32'(1) << mon_e.idx);
      end
    end
  end

  // Requester rule: a pending request holds valid and data until served.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) begin
          checks++;
          if (!req_val[i] || (req_data[i] !== pend_data[i])) begin
            errors++;
            $display("FAIL req_hold[%0d]: got val %b data %h expected val 1 data %h",
                     i, req_val[i], req_data[i], pend_data[i]);
          end
        end
      end
      pend <= req_val & ~req_rdy;
      for (int i = 0; i < NR; i++) pend_data[i] <= req_data[i];
    end
  end

  initial begin
    rst_n       = 1'b0;
    req_val     = '0;
    out_rdy     = 1'b0;
    req_data[0] = 32'h1111_0000;
    req_data[1] = 32'hDEAD_BEEF;
    req_data[2] = 32'h2222_0002;
    req_data[3] = 32'h3333_0003;

    repeat (3) cyc();
    #1;
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_grant_oh", 32'(grant_oh), 32'd0);
    chk("rst_grant_idx", 32'(grant_idx), 32'd0);
    chk("rst_out_data", out_data, 32'h1111_0000);
    rst_n = 1'b1;
    cyc();

    // All four requesting: strict rotation, then drain the leftovers.
    for (int k = 0; k < 8; k++) beat(4'b1111, k % 4);
    beat(4'b0111, 0);
    beat(4'b0110, 1);
    beat(4'b0100, 2);

    // Sparse requests from prio_ptr=3: alternate 0 and 2.
    beat(4'b0101, 0);
    beat(4'b0101, 2);
    beat(4'b0101, 0);
    beat(4'b0100, 2);

    // Idle for 10 cycles; prio_ptr must stay at 3.
    req_val = '0;
    #1;
    chk("idle_out_val", 32'(out_val), 32'd0);
    chk("idle_grant_oh", 32'(grant_oh), 32'd0);
    chk("idle_grant_idx", 32'(grant_idx), 32'd0);
    repeat (10) cyc();
    #1;
    chk("idle_end_out_val", 32'(out_val), 32'd0);
    chk("idle_end_req_rdy", 32'(req_rdy), 32'd0);

    // Pointer wrap: 3 first, then 0, then 3 again.
    beat(4'b1001, 3);
    beat(4'b1001, 0);
    beat(4'b1000, 3);

    // Stall on requester 1; requester 0 arrives but the grant is held.
    req_val = 4'b0010;
    out_rdy = 1'b0;
    #1;
    chk("stall_grant_idx", 32'(grant_idx), 32'd1);
    chk("stall_out_val", 32'(out_val), 32'd1);
    chk("stall_out_data", out_data, 32'hDEAD_BEEF);
    chk("stall_req_rdy", 32'(req_rdy), 32'd0);
    repeat (3) cyc();
    req_val = 4'b0011;
    #1;
    chk("lock_grant_idx", 32'(grant_idx), 32'd1);
    chk("lock_out_data", out_data, 32'hDEAD_BEEF);
    chk("lock_grant_oh", 32'(grant_oh), 32'b0010);
    chk("lock_req_rdy", 32'(req_rdy), 32'd0);
    cyc();
    chk("lock2_grant_idx", 32'(grant_idx), 32'd1);
    push(1);
    out_rdy = 1'b1;
    cyc();
    req_val = 4'b0001;
    #1;
    chk("wrap_grant_idx", 32'(grant_idx), 32'd0);
    push(0);
    cyc();
    req_val = '0;
    out_rdy = 1'b0;

    // Reset pulsed while stalled on requester 2.
    req_val = 4'b0100;
    #1;
    chk("pre_rst_grant_idx", 32'(grant_idx), 32'd2);
    cyc();
    cyc();
    rst_n   = 1'b0;
    req_val = '0;
    #1;
    chk("mid_rst_out_val", 32'(out_val), 32'd0);
    chk("mid_rst_grant_idx", 32'(grant_idx), 32'd0);
    chk("mid_rst_grant_oh", 32'(grant_oh), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    push(1);
    req_val = 4'b0110;
    out_rdy = 1'b1;
    #1;
    chk("post_rst_grant_idx", 32'(grant_idx), 32'd1);
    cyc();
    beat(4'b0100, 2);
    req_val = '0;
    out_rdy = 1'b0;

    for (int k = 0; k < 20 && sb.size() != 0; k++) cyc();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dl_rr_arb.md
# dl_rr_arb

Round-robin arbiter that shares one valid/ready output channel among `NUM_REQS` requesters, each presenting a `NUM_BITS` payload. It picks a winner fairly, locks the grant while the downstream channel stalls, and drives the payload and the select index used by the design_lib muxes. It sits in front of shared resources such as memory ports, writeback buses and register-file write ports.

## Interface
- `NUM_REQS`, 4: number of requesters; must be ≥ 2.
- `NUM_BITS`, 32: payload width.
- `IDX_W`, `$clog2(NUM_REQS)`: derived localparam, not overridable.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_val`  in  `NUM_REQS`  per-requester valid.
- `req_data`  in  `NUM_REQS`×`NUM_BITS`  per-requester payload (unpacked array).
- `req_rdy`  out  `NUM_REQS`  per-requester ready; one-hot or zero.
- `out_val`  out  1  shared channel valid.
- `out_data`  out  `NUM_BITS`  shared channel payload.
- `out_rdy`  in  1  downstream ready.
- `grant_idx`  out  `IDX_W`  index of the current grantee.
- `grant_oh`  out  `NUM_REQS`  one-hot grant; zero when `out_val`=0.

## Operation
- Requester rule: once `req_val[i]` is asserted, it holds with stable `req_data[i]` until `req_rdy[i]`. The block does not check this; the bench asserts it.
- State: `prio_ptr` (`IDX_W`), `locked` (1), `lock_idx` (`IDX_W`).
- Pick: the first `i` with `req_val[i]`=1, scanning `prio_ptr`, `prio_ptr+1`, … modulo `NUM_REQS`.
- Grant:
  - `locked`=1: grant is `lock_idx`.
  - Otherwise: grant is the pick.
  - No request and unlocked: `grant_idx`=0 and `grant_oh`=0.
- `out_val` = `req_val[grant]` (OR of `req_val` when unlocked); `out_data` = `req_data[grant]`.
- `req_rdy[i]` = `out_val & out_rdy & (grant==i)`.
- Stall (`out_val` & !`out_rdy`): `locked`<=1, `lock_idx`<=grant. The grant cannot change while a stall persists, even if a higher-priority request arrives.
- Handshake (`out_val` & `out_rdy`): `locked`<=0, `prio_ptr`<=grant+1, wrapping `NUM_REQS-1`→0.
- `prio_ptr` is unchanged in all other cycles.
- A single requester may win back-to-back only if no other requester is valid.

## Timing
- Reset: `prio_ptr`=0, `locked`=0, `lock_idx`=0. Outputs follow combinationally: with no requests, `out_val`=0, `req_rdy`=0, `grant_oh`=0, `grant_idx`=0, `out_data`=`req_data[0]`.
- Default build: zero latency, combinational `req_*`→`out_*` path, one transfer per cycle.
- Reset asserted mid-stall clears the lock immediately. After release, arbitration restarts from requester 0.

## Configuration
- `DL_RR_ARB_OUTREG_EN` defined: a one-entry output register breaks the combinational path.
  - `out_val`, `out_data` and `grant_idx` are flops; reset values 0.
  - Accept condition: `!out_val | out_rdy`. On accept, the register loads the pick and `prio_ptr` advances past it.
  - `req_rdy[i]` = `req_val[i]` & accept & (pick==i).
  - Lock state is unused, since the register holds the stalled beat.
  - Latency is 1 cycle, full throughput is kept, and `req_rdy` has no dependency on `out_rdy`'s data path beyond the accept term.
- Undefined: combinational behaviour as described in Operation and Timing.

## Structure
- Package `dl_arb_pkg`:
  - `function automatic rr_pick(val, ptr)`, returning index plus found flag.
  - `typedef` for the `{locked, lock_idx}` lock state.
- Sub-module `dl_rr_arb_pick`: combinational rotate/priority-encode/unrotate of `req_val` by `prio_ptr`, producing index, one-hot and found. It is reusable by other schedulers.
- The payload select is an indexed read with no separate mux instance.

## Test plan
- After reset, `req_val`=4'b1111 and `out_rdy`=1 held for 8 cycles → grants in order 0,1,2,3,0,1,2,3, one handshake per cycle (1 cycle later with `DL_RR_ARB_OUTREG_EN`).
- `req_val`=4'b0101, `out_rdy`=1 → grants alternate 0,2,0,2; `req_rdy[1]` and `req_rdy[3]` stay 0.
- Requester 1 valid with data 32'hDEAD_BEEF, `out_rdy`=0 for 3 cycles, then requester 0 raises valid → `grant_idx` stays 1 and `out_data` stays 32'hDEAD_BEEF. When `out_rdy`=1, requester 1 completes and the next grant is 0 via wrap.
- `prio_ptr`=3 with `req_val`=4'b1001 → grant 3, then `prio_ptr` wraps to 0 and grants 0.
- `rst_n` pulsed low mid-stall on requester 2 → `out_val`=0 during reset. After release with `req_val`=4'b0110, grant is 1.
- Idle, `req_val`=0 → `out_val`=0, `grant_oh`=0, and `prio_ptr` is unchanged across 10 cycles.
